// File: rtl/ula_pipe_nbits_if.sv
// Operand/result bus of the pipelined ULA: issue side (valid/ready + operands)
// and result side (valid/ready + f and flags).
interface ula_pipe_nbits_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       s;
    logic             m;
    logic             c_in;
    logic             acc_sel;
    logic             chain;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;
    logic             c_out;
    logic             a_eq_b;

    modport master (
        output in_valid, a, b, s, m, c_in, acc_sel, chain, out_ready,
        input  in_ready, out_valid, f, c_out, a_eq_b
    );

    modport slave (
        input  in_valid, a, b, s, m, c_in, acc_sel, chain, out_ready,
        output in_ready, out_valid, f, c_out, a_eq_b
    );
endinterface

// File: rtl/ula_pipe_nbits.sv
// Two-stage valid/ready 74181-style ALU of any WIDTH (multiple of 4), with an
// accumulator operand and a stored carry for multi-word chaining.
module ula_pipe_nbits #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    ula_pipe_nbits_if.slave   bus
);
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
        $error("ula_pipe_nbits: WIDTH must be a multiple of 4 and >= 4");
    end

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [3:0]       s1_s_q;
    logic             s1_m_q;
    logic             s1_cin_q;
    logic             s1_acc_sel_q;
    logic             s1_chain_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] f_q;
    logic             c_out_q;
    logic             a_eq_b_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;

    logic [WIDTH-1:0] f_d;
    logic             c_out_d;
    logic             a_eq_b_d;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH:0]   sum;
    logic             cin_eff;
    logic             s1_adv;
    logic             in_ready;

    // S1 may drain whenever S2 is free this cycle, so the ready path never
    // depends on in_valid.
    assign s1_adv   = s1_valid_q & (~out_valid_q | bus.out_ready);
    assign in_ready = ~s1_valid_q | s1_adv;

    always_comb begin
        op_a     = s1_acc_sel_q ? acc_q : s1_a_q;
        cin_eff  = s1_chain_q ? carry_q : s1_cin_q;
        x        = op_a | (s1_b_q & {WIDTH{s1_s_q[0]}}) | (~s1_b_q & {WIDTH{s1_s_q[1]}});
        y        = (op_a & ~s1_b_q & {WIDTH{s1_s_q[2]}}) | (op_a & s1_b_q & {WIDTH{s1_s_q[3]}});
        sum      = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ~cin_eff};
        f_d      = sum[WIDTH-1:0];
        c_out_d  = ~sum[WIDTH];
        if (s1_m_q) begin
            f_d     = ~(x ^ y);
            c_out_d = 1'b1;
        end
        a_eq_b_d = &f_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= bus.in_valid;
        end
    end

    // Payload is only meaningful while s1_valid_q is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (bus.in_valid && in_ready) begin
            s1_a_q       <= bus.a;
            s1_b_q       <= bus.b;
            s1_s_q       <= bus.s;
            s1_m_q       <= bus.m;
            s1_cin_q     <= bus.c_in;
            s1_acc_sel_q <= bus.acc_sel;
            s1_chain_q   <= bus.chain;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            f_q         <= '0;
            c_out_q     <= 1'b1;
            a_eq_b_q    <= 1'b0;
            acc_q       <= '0;
            carry_q     <= 1'b1;
        end else if (s1_adv) begin
            out_valid_q <= 1'b1;
            f_q         <= f_d;
            c_out_q     <= c_out_d;
            a_eq_b_q    <= a_eq_b_d;
            acc_q       <= f_d;
            carry_q     <= c_out_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.f         = f_q;
    assign bus.c_out     = c_out_q;
    assign bus.a_eq_b    = a_eq_b_q;
endmodule

// File: tb/tb_ula_pipe_nbits.sv
// Bench for ula_pipe_nbits: directed vector table, pipeline corner sequences,
// and randomized traffic against an in-order sequential reference model.
module tb_ula_pipe_nbits;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ula_pipe_nbits_if #(.WIDTH(8))  bus8 ();
    ula_pipe_nbits_if #(.WIDTH(16)) bus16 ();

    ula_pipe_nbits #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    ula_pipe_nbits #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] s;
        logic       m;
        logic       cin;
        logic       acc_sel;
        logic       chain;
        logic [7:0] f;
        logic       cout;
        logic       eq;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sequential meaning of one op: returns {c_out, a_eq_b, f}.
    function automatic logic [9:0] ref_alu(input int a, input int b, input logic [3:0] s,
                                           input logic m, input logic cin);
        int x, y, t, fv;
        logic co;
        x = a | (s[0] ? b : 0) | (s[1] ? (~b & 255) : 0);
        y = (s[2] ? (a & ~b & 255) : 0) | (s[3] ? (a & b) : 0);
        if (m) begin
            fv = ~(x ^ y) & 255;
            co = 1'b1;
        end else begin
            t  = x + y + (cin ? 0 : 1);
            fv = t & 255;
            co = (t > 255) ? 1'b0 : 1'b1;
        end
        return {co, (fv == 255), 8'(fv)};
    endfunction

    task automatic drive(input vec_t v);
        bus8.a       = v.a;
        bus8.b       = v.b;
        bus8.s       = v.s;
        bus8.m       = v.m;
        bus8.c_in    = v.cin;
        bus8.acc_sel = v.acc_sel;
        bus8.chain   = v.chain;
    endtask

    // One isolated op: accepted at an edge, result visible after the following edge.
    task automatic issue_check(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        bus8.in_valid  = 1'b1;
        bus8.out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, 32'(bus8.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        #1 check({tag, "_early_valid"}, 32'(bus8.out_valid), 32'd0);
        @(negedge clk);
        #1;
        check({tag, "_out_valid"}, 32'(bus8.out_valid), 32'd1);
        check({tag, "_f"},         32'(bus8.f),         32'(v.f));
        check({tag, "_c_out"},     32'(bus8.c_out),     32'(v.cout));
        check({tag, "_a_eq_b"},    32'(bus8.a_eq_b),    32'(v.eq));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus8.in_valid  = 1'b0;
        bus16.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t v;
        vec_t bp [3];
        logic [7:0] bp_exp [3];
        logic [9:0] expq [$];
        logic [9:0] e;
        logic [7:0] macc;
        logic       mcarry;
        logic       acc, take, hold;
        logic [7:0] hold_f;
        logic       hold_c, hold_e;
        int idx, got;

        bus8.in_valid = 0; bus8.a = 0; bus8.b = 0; bus8.s = 0; bus8.m = 0;
        bus8.c_in = 1; bus8.acc_sel = 0; bus8.chain = 0; bus8.out_ready = 1;
        bus16.in_valid = 0; bus16.a = 0; bus16.b = 0; bus16.s = 0; bus16.m = 0;
        bus16.c_in = 1; bus16.acc_sel = 0; bus16.chain = 0; bus16.out_ready = 1;

        tbl[0] = '{8'h00, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0};
        tbl[1] = '{8'h3C, 8'h3C, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1};
        tbl[2] = '{8'h3D, 8'h3C, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[3] = '{8'hF0, 8'h20, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        tbl[4] = '{8'h00, 8'h00, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        tbl[5] = '{8'hA5, 8'hFF, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0};
        tbl[6] = '{8'hFF, 8'h00, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1};
        tbl[7] = '{8'h10, 8'h01, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0};
        tbl[8] = '{8'hFF, 8'h01, 4'b1001, 1'b0, 1'b0, 1'b1, 1'b0, 8'h13, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        check("rst_f",         32'(bus8.f),         32'd0);
        check("rst_c_out",     32'(bus8.c_out),     32'd1);
        check("rst_a_eq_b",    32'(bus8.a_eq_b),    32'd0);
        rst_n = 1'b1;
        #1 check("rst_in_ready", 32'(bus8.in_ready), 32'd1);

        // WIDTH=16 wrap: FFFF + 1
        @(negedge clk);
        bus16.a = 16'hFFFF; bus16.b = 16'h0000; bus16.s = 4'b0000;
        bus16.m = 1'b0; bus16.c_in = 1'b0; bus16.in_valid = 1'b1;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("w16_out_valid", 32'(bus16.out_valid), 32'd1);
        check("w16_f",         32'(bus16.f),         32'h0000);
        check("w16_c_out",     32'(bus16.c_out),     32'd0);

        for (int i = 0; i < 9; i++) issue_check(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back dependent accumulator ops
        do_reset();
        v = '{8'h00, 8'h00, 4'b1001, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        bus8.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(v);
            bus8.in_valid = (k < 3);
            #1;
            if (k < 3) check($sformatf("b2b_in_ready%0d", k), 32'(bus8.in_ready), 32'd1);
            if (k >= 2) begin
                check($sformatf("b2b_valid%0d", k), 32'(bus8.out_valid), 32'd1);
                check($sformatf("b2b_f%0d", k),     32'(bus8.f),         32'(k - 1));
            end
        end
        bus8.in_valid = 1'b0;

        // Backpressure: three logic ops with the consumer stalled
        bp[0] = '{8'hA5, 8'hFF, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        bp[1] = '{8'h0F, 8'hFF, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        bp[2] = '{8'h00, 8'h00, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        bp_exp[0] = 8'h5A; bp_exp[1] = 8'hF0; bp_exp[2] = 8'h00;
        do_reset();
        bus8.out_ready = 1'b0;
        idx = 0;
        repeat (6) begin
            @(negedge clk);
            if (idx < 3) begin drive(bp[idx]); bus8.in_valid = 1'b1; end
            else bus8.in_valid = 1'b0;
            #1 acc = bus8.in_valid & bus8.in_ready;
            @(posedge clk);
            if (acc) idx++;
        end
        @(negedge clk);
        #1;
        check("bp_accepted",  32'(idx),            32'd2);
        check("bp_in_ready",  32'(bus8.in_ready),  32'd0);
        check("bp_out_valid", 32'(bus8.out_valid), 32'd1);
        check("bp_f_held",    32'(bus8.f),         32'h5A);
        check("bp_c_out",     32'(bus8.c_out),     32'd1);
        got = 0;
        bus8.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            if (idx < 3) begin drive(bp[idx]); bus8.in_valid = 1'b1; end
            else bus8.in_valid = 1'b0;
            #1;
            acc  = bus8.in_valid & bus8.in_ready;
            take = bus8.out_valid & bus8.out_ready;
            if (take) begin
                if (got < 3) check($sformatf("bp_order%0d", got), 32'(bus8.f), 32'(bp_exp[got]));
                got++;
            end
            @(posedge clk);
            if (acc) idx++;
        end
        check("bp_result_count", 32'(got), 32'd3);

        // Reset with two ops in flight, then prove acc_q=0 and carry_q=1
        do_reset();
        bus8.out_ready = 1'b0;
        @(negedge clk);
        drive(tbl[0]);
        bus8.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1 check("rst2_in_ready_full", 32'(bus8.in_ready), 32'd0);
        rst_n = 1'b0;
        bus8.in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("rst2_out_valid", 32'(bus8.out_valid), 32'd0);
        check("rst2_f",         32'(bus8.f),         32'd0);
        check("rst2_c_out",     32'(bus8.c_out),     32'd1);
        check("rst2_in_ready",  32'(bus8.in_ready),  32'd1);
        rst_n = 1'b1;
        issue_check('{8'hFF, 8'h00, 4'b1001, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0}, "rst2_acc");
        do_reset();
        issue_check('{8'h00, 8'h00, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0}, "rst2_carry");

        // Randomized traffic against the sequential model
        do_reset();
        macc = 8'h00;
        mcarry = 1'b1;
        hold = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            bus8.in_valid  = ($urandom_range(0, 3) != 0);
            bus8.out_ready = (c < 560) ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (c >= 540) bus8.in_valid = 1'b0;
            bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.s = 4'($urandom);
            bus8.m = 1'($urandom); bus8.c_in = 1'($urandom);
            bus8.acc_sel = 1'($urandom); bus8.chain = 1'($urandom);
            #1;
            if (hold) begin
                check("rnd_hold_f",     32'(bus8.f),      32'(hold_f));
                check("rnd_hold_c_out", 32'(bus8.c_out),  32'(hold_c));
                check("rnd_hold_eq",    32'(bus8.a_eq_b), 32'(hold_e));
            end
            check("rnd_in_ready", 32'(bus8.in_ready),
                  32'((expq.size() < 2) || bus8.out_ready));
            acc  = bus8.in_valid & bus8.in_ready;
            take = bus8.out_valid & bus8.out_ready;
            if (take) begin
                if (expq.size() == 0) begin
                    check("rnd_spurious_result", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("rnd_f",     32'(bus8.f),      32'(e[7:0]));
                    check("rnd_c_out", 32'(bus8.c_out),  32'(e[9]));
                    check("rnd_a_eq_b", 32'(bus8.a_eq_b), 32'(e[8]));
                end
            end
            if (acc) begin
                e = ref_alu(int'(bus8.acc_sel ? macc : bus8.a), int'(bus8.b), bus8.s,
                            bus8.m, bus8.chain ? mcarry : bus8.c_in);
                expq.push_back(e);
                macc   = e[7:0];
                mcarry = e[9];
            end
            hold   = bus8.out_valid & ~bus8.out_ready;
            hold_f = bus8.f;
            hold_c = bus8.c_out;
            hold_e = bus8.a_eq_b;
        end
        check("rnd_drained", 32'(expq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
